fp_div_seq: RTL and testbench
=============================

Name: fp_div_seq

Overview:
Iterative single-precision IEEE-754 divider. It is the inverse companion of the FP multiplier, computing fp_Z = fp_X / fp_Y with the same rounding-mode encoding, the same subnormal flush-to-zero policy and the same ovrf/udrf flag semantics. It uses a radix-2 restoring quotient loop, then a normalise/round stage. A start/done handshake lets the ALU issue one divide at a time.

Parameters:
ITER, 27, number of quotient bits generated: 1 integer bit, 23 fraction bits, guard bit, and 2 extra bits that feed sticky.

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous and active-low
start  in  1  request; sampled only in IDLE
fp_X  in  32  dividend, captured when start is accepted
fp_Y  in  32  divisor, captured when start is accepted
r_mode  in  3  rounding mode, captured when start is accepted
busy  out  1  high from the acceptance edge until done
done  out  1  one-cycle pulse; fp_Z and all flags valid in that cycle
fp_Z  out  32  quotient, held until the next done
ovrf  out  1  overflow flag, held with fp_Z
udrf  out  1  underflow flag, held with fp_Z
dz  out  1  divide-by-zero flag (finite nonzero / zero), held with fp_Z

Behaviour:
- Reset (asynchronous): state=IDLE; busy, done, ovrf, udrf and dz all 0; fp_Z=32'h0; counter=0.
- States and transitions:
  - IDLE: on start=1, go to CLASSIFY.
  - CLASSIFY: go to DONE for any special case, otherwise ITER.
  - ITER: runs 27 cycles, then ROUND.
  - ROUND: go to DONE.
  - DONE: pulses done for one cycle, then IDLE.
- start is ignored outside IDLE. rst_n low mid-operation aborts immediately with no done pulse.
- Latency, counting the accepting edge as edge 0:
  - Normal operands: done high after edge 30.
  - Special cases: done high after edge 2.
  - busy and done are never both high. busy falls in the same edge that raises done.
- Operand classification:
  - Exponent 0 means zero, regardless of fraction (flush-to-zero).
  - Exponent FF with fraction 0 is inf; with fraction nonzero it is NaN.
- Special results, with sign = X[31]^Y[31]:
  - Any NaN, 0/0 or inf/inf gives 32'h7FC00000.
  - inf/finite gives signed inf.
  - Nonzero finite/0 gives signed inf with dz=1.
  - 0/finite or finite/inf gives signed zero.
  - ovrf and udrf are 0 for all special cases.
- Quotient loop:
  - Initialise R = {1,frac_X} and D = {1,frac_Y}, both 25 bits.
  - Each cycle: if R>=D then q bit=1 and R=R-D, else q bit=0; then R=R<<1.
  - Quotient bits are produced MSB-first into q[26:0].
- Normalise:
  - If q[26]=1: mantissa = q[25:3], G = q[2], S = |q[1:0] | (R!=0), exponent adjust 0.
  - Otherwise: mantissa = q[24:2], G = q[1], S = q[0] | (R!=0), exponent adjust -1.
  - E = exp_X - exp_Y + 127 + adjust, computed in a 10-bit signed register.
- Rounding, where inc applies to the mantissa and inexact = G|S:
  - 000 RNE: inc = G & (S | mantissa[0]).
  - 001 RTZ: inc = 0.
  - 010 RDN: inc = inexact & sign.
  - 011 RUP: inc = inexact & ~sign.
  - 100 RMM: inc = G.
  - 101-111 are treated as RNE.
  - A mantissa carry-out sets mantissa = 0 and E = E+1.
- Overflow, when E>=255 after rounding: ovrf=1, with result by mode:
  - RNE/RMM: signed inf.
  - RTZ: signed 7F7FFFFF.
  - RDN: +max finite if positive, -inf if negative.
  - RUP: +inf if positive, -max finite if negative.
- Underflow, when E<=0: udrf=1, result is signed zero (no subnormal output).

Test Plan:
- 40C00000 / 40000000, RNE -> 40400000 (3.0), no flags, done exactly after edge 30, busy high for edges 0-29.
- 3F800000 / 40400000 (1/3) -> RNE 3EAAAAAB, RTZ 3EAAAAAA, RDN 3EAAAAAA, RUP 3EAAAAAB. Sign-flipped BF800000 with RDN -> BEAAAAAB.
- 3F800000 / 00000000 -> 7F800000, dz=1, done after edge 2. 00000000 / 00000000 -> 7FC00000, dz=0.
- 7F000000 / 3E800000 -> RNE 7F800000 with ovrf=1; RTZ 7F7FFFFF with ovrf=1.
- 00800000 / 40000000 -> 00000000, udrf=1. Subnormal input 00000001 / 3F800000 -> 00000000, no flags.
- Second start pulsed at edge 10 is ignored and the first result is unaffected. rst_n low at edge 15 -> all outputs 0 and no done; the next start completes normally.

Source files
------------

// File: rtl/fp_div_seq_if.sv
// Start/done handshake between the ALU issue logic and the iterative FP divider.
// The master drives operands and start; the slave returns the held result and flags.
interface fp_div_seq_if;
  logic        start;
  logic [31:0] fp_X;
  logic [31:0] fp_Y;
  logic [2:0]  r_mode;
  logic        busy;
  logic        done;
  logic [31:0] fp_Z;
  logic        ovrf;
  logic        udrf;
  logic        dz;

  modport master (
    output start, fp_X, fp_Y, r_mode,
    input  busy, done, fp_Z, ovrf, udrf, dz
  );

  modport slave (
    input  start, fp_X, fp_Y, r_mode,
    output busy, done, fp_Z, ovrf, udrf, dz
  );
endinterface

// File: rtl/fp_div_seq.sv
// Iterative single-precision divider (restoring radix-2, flush-to-zero); done 30 edges after accept, 2 for specials.
// One divide in flight: start is ignored while busy, result and flags hold until the next done.
module fp_div_seq #(
  parameter int ITER = 27
) (
  input logic         clk,
  input logic         rst_n,
  fp_div_seq_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLASSIFY, S_ITER, S_ROUND, S_DONE} state_t;

  state_t             state;
  logic [31:0]        x_q, y_q;
  logic [2:0]         mode_q;
  logic [4:0]         cnt;
  logic [25:0]        rem;
  logic [26:0]        quo;
  logic signed [9:0]  exp_base;
  logic [31:0]        res_z;
  logic               res_ovrf, res_udrf, res_dz;

  // Operand classification
  logic sign, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic spec_hit, spec_dz;
  logic [31:0] spec_z;
  logic signed [9:0] exp_calc;

  assign sign   = x_q[31] ^ y_q[31];
  assign x_zero = (x_q[30:23] == 8'h00);
  assign y_zero = (y_q[30:23] == 8'h00);
  assign x_inf  = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
  assign y_inf  = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);
  assign x_nan  = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
  assign y_nan  = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
  assign exp_calc = $signed({2'b00, x_q[30:23]}) - $signed({2'b00, y_q[30:23]}) + 10'sd127;

  always_comb begin
    spec_hit = 1'b1;
    spec_dz  = 1'b0;
    spec_z   = 32'h7FC0_0000;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      spec_z = 32'h7FC0_0000;
    end else if (x_inf) begin
      spec_z = {sign, 8'hFF, 23'd0};
    end else if (y_zero) begin
      spec_z  = {sign, 8'hFF, 23'd0};
      spec_dz = 1'b1;
    end else if (x_zero || y_inf) begin
      spec_z = {sign, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // One restoring quotient step
  logic [24:0] divisor;
  logic        rem_ge;
  logic [25:0] rem_sub, rem_nxt;

  assign divisor = {1'b1, y_q[22:0]};
  assign rem_ge  = (rem >= {1'b0, divisor});
  assign rem_sub = rem_ge ? (rem - {1'b0, divisor}) : rem;
  assign rem_nxt = rem_sub << 1;

  // Normalise and round
  logic [22:0]       mant;
  logic              g_bit, s_bit, inc;
  logic [23:0]       mant_sum;
  logic signed [9:0] exp_adj, exp_rnd;
  logic [31:0]       rnd_z;
  logic              rnd_ovrf, rnd_udrf;

  always_comb begin
    if (quo[26]) begin
      mant    = quo[25:3];
      g_bit   = quo[2];
      s_bit   = (|quo[1:0]) | (|rem);
      exp_adj = exp_base;
    end else begin
      mant    = quo[24:2];
      g_bit   = quo[1];
      s_bit   = quo[0] | (|rem);
      exp_adj = exp_base - 10'sd1;
    end

    case (mode_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = (g_bit | s_bit) & sign;
      3'b011:  inc = (g_bit | s_bit) & ~sign;
      3'b100:  inc = g_bit;
      default: inc = g_bit & (s_bit | mant[0]);
    endcase

    mant_sum = {1'b0, mant} + {23'd0, inc};
    exp_rnd  = exp_adj + $signed({9'd0, mant_sum[23]});

    rnd_ovrf = 1'b0;
    rnd_udrf = 1'b0;
    rnd_z    = {sign, exp_rnd[7:0], mant_sum[22:0]};
    if (exp_rnd >= 10'sd255) begin
      rnd_ovrf = 1'b1;
      case (mode_q)
        3'b001:  rnd_z = {sign, 31'h7F7F_FFFF};
        3'b010:  rnd_z = sign ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        3'b011:  rnd_z = sign ? 32'hFF7F_FFFF : 32'h7F80_0000;
        default: rnd_z = {sign, 8'hFF, 23'd0};
      endcase
    end else if (exp_rnd <= 10'sd0) begin
      rnd_udrf = 1'b1;
      rnd_z    = {sign, 31'd0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      x_q      <= 32'd0;
      y_q      <= 32'd0;
      mode_q   <= 3'd0;
      cnt      <= 5'd0;
      rem      <= 26'd0;
      quo      <= 27'd0;
      exp_base <= 10'sd0;
      res_z    <= 32'd0;
      res_ovrf <= 1'b0;
      res_udrf <= 1'b0;
      res_dz   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.fp_Z <= 32'd0;
      bus.ovrf <= 1'b0;
      bus.udrf <= 1'b0;
      bus.dz   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            x_q      <= bus.fp_X;
            y_q      <= bus.fp_Y;
            mode_q   <= bus.r_mode;
            bus.busy <= 1'b1;
            state    <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          if (spec_hit) begin
            res_z    <= spec_z;
            res_ovrf <= 1'b0;
            res_udrf <= 1'b0;
            res_dz   <= spec_dz;
            state    <= S_DONE;
          end else begin
            exp_base <= exp_calc;
            rem      <= {2'b01, x_q[22:0]};
            quo      <= 27'd0;
            cnt      <= 5'd0;
            state    <= S_ITER;
          end
        end
        S_ITER: begin
          rem <= rem_nxt;
          quo <= {quo[25:0], rem_ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITER - 1)) state <= S_ROUND;
        end
        S_ROUND: begin
          res_z    <= rnd_z;
          res_ovrf <= rnd_ovrf;
          res_udrf <= rnd_udrf;
          res_dz   <= 1'b0;
          state    <= S_DONE;
        end
        S_DONE: begin
          bus.fp_Z <= res_z;
          bus.ovrf <= res_ovrf;
          bus.udrf <= res_udrf;
          bus.dz   <= res_dz;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed vectors for the iterative FP divider: results, flags, latency, busy/done timing, ignored start, reset abort.
module tb_fp_div_seq;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  fp_div_seq_if bus_i ();

  fp_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide, count edges to done (accept edge = 0), check busy/done timing and the held result.
  task automatic run_div(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] m, input logic [31:0] ez,
                         input logic eo, input logic eu, input logic ed,
                         input int elat, input int poke);
    int lat;
    int busy_cnt;
    int both;
    lat      = -1;
    busy_cnt = 0;
    both     = 0;
    @(negedge clk);
    bus_i.start  = 1'b1;
    bus_i.fp_X   = x;
    bus_i.fp_Y   = y;
    bus_i.r_mode = m;
    @(posedge clk);
    #1;
    bus_i.start = 1'b0;
    if (bus_i.busy) busy_cnt++;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      if (n == poke) begin
        bus_i.start  = 1'b1;
        bus_i.fp_X   = 32'h3F80_0000;
        bus_i.fp_Y   = 32'h0000_0000;
        bus_i.r_mode = 3'b001;
      end
      @(posedge clk);
      #1;
      bus_i.start = 1'b0;
      if (bus_i.busy && bus_i.done) both++;
      if (bus_i.done) lat = n;
      else if (bus_i.busy) busy_cnt++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " busy_edges"}, 32'(busy_cnt), 32'(elat));
    chk({tag, " busy_and_done"}, 32'(both), 32'd0);
    chk({tag, " fp_Z"}, bus_i.fp_Z, ez);
    chk({tag, " flags"}, {29'd0, bus_i.ovrf, bus_i.udrf, bus_i.dz}, {29'd0, eo, eu, ed});
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, {31'd0, bus_i.done}, 32'd0);
    chk({tag, " fp_Z_hold"}, bus_i.fp_Z, ez);
  endtask

  initial begin
    int done_seen;
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    bus_i.start  = 1'b0;
    bus_i.fp_X   = 32'd0;
    bus_i.fp_Y   = 32'd0;
    bus_i.r_mode = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ctl", {27'd0, bus_i.busy, bus_i.done, bus_i.ovrf, bus_i.udrf, bus_i.dz}, 32'd0);
    chk("reset fp_Z", bus_i.fp_Z, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("6/2 rne",      32'h40C0_0000, 32'h4000_0000, 3'b000, 32'h4040_0000, 0, 0, 0, 30, 0);
    run_div("1/3 rne",      32'h3F80_0000, 32'h4040_0000, 3'b000, 32'h3EAA_AAAB, 0, 0, 0, 30, 0);
    run_div("1/3 rtz",      32'h3F80_0000, 32'h4040_0000, 3'b001, 32'h3EAA_AAAA, 0, 0, 0, 30, 0);
    run_div("1/3 rdn",      32'h3F80_0000, 32'h4040_0000, 3'b010, 32'h3EAA_AAAA, 0, 0, 0, 30, 0);
    run_div("1/3 rup",      32'h3F80_0000, 32'h4040_0000, 3'b011, 32'h3EAA_AAAB, 0, 0, 0, 30, 0);
    run_div("1/3 rmm",      32'h3F80_0000, 32'h4040_0000, 3'b100, 32'h3EAA_AAAB, 0, 0, 0, 30, 0);
    run_div("1/3 mode5",    32'h3F80_0000, 32'h4040_0000, 3'b101, 32'h3EAA_AAAB, 0, 0, 0, 30, 0);
    run_div("-1/3 rdn",     32'hBF80_0000, 32'h4040_0000, 3'b010, 32'hBEAA_AAAB, 0, 0, 0, 30, 0);
    run_div("1/0 dz",       32'h3F80_0000, 32'h0000_0000, 3'b000, 32'h7F80_0000, 0, 0, 1, 2, 0);
    run_div("0/0 nan",      32'h0000_0000, 32'h0000_0000, 3'b000, 32'h7FC0_0000, 0, 0, 0, 2, 0);
    run_div("nan/1",        32'h7F80_0001, 32'h3F80_0000, 3'b000, 32'h7FC0_0000, 0, 0, 0, 2, 0);
    run_div("inf/inf",      32'h7F80_0000, 32'hFF80_0000, 3'b000, 32'h7FC0_0000, 0, 0, 0, 2, 0);
    run_div("-inf/2",       32'hFF80_0000, 32'h4000_0000, 3'b000, 32'hFF80_0000, 0, 0, 0, 2, 0);
    run_div("-2/inf",       32'hC000_0000, 32'h7F80_0000, 3'b000, 32'h8000_0000, 0, 0, 0, 2, 0);
    run_div("ovf rne",      32'h7F00_0000, 32'h3E80_0000, 3'b000, 32'h7F80_0000, 1, 0, 0, 30, 0);
    run_div("ovf rtz",      32'h7F00_0000, 32'h3E80_0000, 3'b001, 32'h7F7F_FFFF, 1, 0, 0, 30, 0);
    run_div("neg ovf rdn",  32'hFF00_0000, 32'h3E80_0000, 3'b010, 32'hFF80_0000, 1, 0, 0, 30, 0);
    run_div("neg ovf rup",  32'hFF00_0000, 32'h3E80_0000, 3'b011, 32'hFF7F_FFFF, 1, 0, 0, 30, 0);
    run_div("udf",          32'h0080_0000, 32'h4000_0000, 3'b000, 32'h0000_0000, 0, 1, 0, 30, 0);
    run_div("subnormal/1",  32'h0000_0001, 32'h3F80_0000, 3'b000, 32'h0000_0000, 0, 0, 0, 2, 0);
    run_div("ignored start",32'h40C0_0000, 32'h4000_0000, 3'b000, 32'h4040_0000, 0, 0, 0, 30, 10);

    // Abort a divide mid-flight: outputs clear at once and no done ever appears.
    @(negedge clk);
    bus_i.start  = 1'b1;
    bus_i.fp_X   = 32'h3F80_0000;
    bus_i.fp_Y   = 32'h4040_0000;
    bus_i.r_mode = 3'b000;
    @(posedge clk);
    #1;
    bus_i.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort ctl", {27'd0, bus_i.busy, bus_i.done, bus_i.ovrf, bus_i.udrf, bus_i.dz}, 32'd0);
    chk("abort fp_Z", bus_i.fp_Z, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int n = 0; n < 35; n++) begin
      @(posedge clk);
      #1;
      if (bus_i.done || bus_i.busy) done_seen++;
    end
    chk("abort no done", 32'(done_seen), 32'd0);

    run_div("after abort",  32'h40C0_0000, 32'h4000_0000, 3'b000, 32'h4040_0000, 0, 0, 0, 30, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
